// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI transfer engine and the APB slave interface.
//   - spi_mode_e   : spi_mode field encodings (RUN / WAIT / STOP)
//   - spi_state_e  : transfer FSM states
//   - DATA_WIDTH   : transfer length in bits
//   - CNT_WIDTH    : half-period counter width (holds 1..1024)
//   - half_period(): SCLK half-period in PCLK cycles from the SPPR/SPR fields
package spi_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned CNT_WIDTH  = 11;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        STOP = 2'b10
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TAIL
    } spi_state_e;

    // (sppr+1) << spr; the largest value is 8 << 7 = 1024, which fits in CNT_WIDTH.
    function automatic logic [CNT_WIDTH-1:0] half_period(input logic [2:0] sppr,
                                                         input logic [2:0] spr);
        logic [CNT_WIDTH-1:0] base;
        base = CNT_WIDTH'(sppr) + CNT_WIDTH'(1);
        return base << spr;
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: SCLK half-period timer.
//   pclk_i, preset_ni : clock, async active-low reset
//   load_i            : latch the half-period from sppr_i/spr_i
//   sppr_i, spr_i     : baud prescaler / rate fields
//   en_i              : count enable (low freezes the counter in place)
//   clr_i             : synchronous clear of the counter
//   edge_tick_o       : one-cycle pulse at the end of every half-period
module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = spi_pkg::CNT_WIDTH
) (
    input  logic       pclk_i,
    input  logic       preset_ni,
    input  logic       load_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic       edge_tick_o
);

    logic [CNT_WIDTH-1:0] half_q, half_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        half_d      = half_q;
        cnt_d       = cnt_q;
        edge_tick_o = 1'b0;
        if (load_i) begin
            half_d = CNT_WIDTH'(half_period(sppr_i, spr_i));
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == half_q - CNT_WIDTH'(1)) begin
                cnt_d       = '0;
                edge_tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            half_q <= CNT_WIDTH'(1);
            cnt_q  <= '0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: master-mode SPI transfer engine.
//   PCLK, PRESET_n          : clock, async active-low reset
//   send_data_i             : start request pulse (honoured only in IDLE)
//   mosi_data_i             : byte to transmit, captured on the accept cycle
//   mstr_i/cpol_i/cpha_i/lsbfe_i : CR1 control fields
//   sppr_i, spr_i           : baud fields, half-period = (sppr+1) << spr
//   spi_mode_i              : RUN / WAIT transfer normally, STOP freezes a transfer
//   miso_i                  : serial input
//   sclk_o, mosi_o, ss_o    : serial clock, serial output, active-low select
//   tip_o                   : transfer in progress
//   receive_data_o          : one-cycle completion pulse
//   miso_data_o             : last received byte
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = spi_pkg::DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = spi_pkg::CNT_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  send_data_i,
    input  logic [DATA_WIDTH-1:0] mosi_data_i,
    input  logic                  mstr_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsbfe_i,
    input  logic [2:0]            sppr_i,
    input  logic [2:0]            spr_i,
    input  logic [1:0]            spi_mode_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  ss_o,
    output logic                  tip_o,
    output logic                  receive_data_o,
    output logic [DATA_WIDTH-1:0] miso_data_o
);

    localparam int unsigned      NUM_EDGES = 2 * DATA_WIDTH;
    localparam int unsigned      EC_W      = $clog2(NUM_EDGES + 1);
    localparam logic [EC_W-1:0]  LAST_EDGE = EC_W'(NUM_EDGES - 1);

    spi_state_e            state_q, state_d;
    logic                  cpha_q, cpha_d;
    logic                  lsbfe_q, lsbfe_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [EC_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  ss_q, ss_d;
    logic                  tip_q, tip_d;
    logic                  done_q, done_d;

    logic start;
    logic leading;
    logic edge_tick;
    logic baud_en;
    logic baud_clr;

    assign baud_en  = (state_q != ST_IDLE) && (spi_mode_i != STOP);
    assign baud_clr = (state_q == ST_IDLE);

    spi_baud_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_baud (
        .pclk_i      (PCLK),
        .preset_ni   (PRESET_n),
        .load_i      (start),
        .sppr_i      (sppr_i),
        .spr_i       (spr_i),
        .en_i        (baud_en),
        .clr_i       (baud_clr),
        .edge_tick_o (edge_tick)
    );

    always_comb begin
        state_d    = state_q;
        cpha_d     = cpha_q;
        lsbfe_d    = lsbfe_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        tip_d      = tip_q;
        done_d     = 1'b0;
        start      = 1'b0;
        // edge_cnt_q counts edges already taken, so an even count means the
        // upcoming edge is odd-numbered, i.e. a leading edge.
        leading    = ~edge_cnt_q[0];

        unique case (state_q)
            ST_IDLE: begin
                if (send_data_i && mstr_i && (spi_mode_i == RUN || spi_mode_i == WAIT)) begin
                    start      = 1'b1;
                    state_d    = ST_LEAD;
                    cpha_d     = cpha_i;
                    lsbfe_d    = lsbfe_i;
                    sclk_d     = cpol_i;
                    ss_d       = 1'b0;
                    tip_d      = 1'b1;
                    edge_cnt_d = '0;
                    rx_sr_d    = '0;
                    if (cpha_i) begin
                        mosi_d  = 1'b0;
                        tx_sr_d = mosi_data_i;
                    end else begin
                        // cpha=0 presents the first bit during LEAD, so it is
                        // consumed from the shift register immediately.
                        mosi_d  = lsbfe_i ? mosi_data_i[0] : mosi_data_i[DATA_WIDTH-1];
                        tx_sr_d = lsbfe_i ? (mosi_data_i >> 1) : (mosi_data_i << 1);
                    end
                end
            end
            ST_LEAD: begin
                if (edge_tick) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (edge_tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EC_W'(1);
                    if (leading != cpha_q) begin
                        rx_sr_d = lsbfe_q ? {miso_i, rx_sr_q[DATA_WIDTH-1:1]}
                                          : {rx_sr_q[DATA_WIDTH-2:0], miso_i};
                    end
                    if (cpha_q ? leading : (!leading && edge_cnt_q < LAST_EDGE)) begin
                        mosi_d  = lsbfe_q ? tx_sr_q[0] : tx_sr_q[DATA_WIDTH-1];
                        tx_sr_d = lsbfe_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                    end
                    if (edge_cnt_q == LAST_EDGE) state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (edge_tick) begin
                    state_d   = ST_IDLE;
                    ss_d      = 1'b1;
                    tip_d     = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    mosi_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q    <= ST_IDLE;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
            tip_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpha_q     <= cpha_d;
            lsbfe_q    <= lsbfe_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            tip_q      <= tip_d;
            done_q     <= done_d;
        end
    end

    assign sclk_o         = sclk_q;
    assign mosi_o         = mosi_q;
    assign ss_o           = ss_q;
    assign tip_o          = tip_q;
    assign receive_data_o = done_q;
    assign miso_data_o    = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
module tb_spi_shift_engine;

    logic       PCLK = 1'b0;
    logic       PRESET_n = 1'b0;
    logic       send_data_i = 1'b0;
    logic [7:0] mosi_data_i = 8'h00;
    logic       mstr_i = 1'b1;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic       lsbfe_i = 1'b0;
    logic [2:0] sppr_i = 3'd0;
    logic [2:0] spr_i = 3'd0;
    logic [1:0] spi_mode_i = 2'b00;
    logic       miso_i;
    logic       sclk_o, mosi_o, ss_o, tip_o, receive_data_o;
    logic [7:0] miso_data_o;

    logic loop_en = 1'b0;
    logic slave_miso = 1'b0;
    assign miso_i = loop_en ? mosi_o : slave_miso;

    spi_shift_engine dut (
        .PCLK           (PCLK),
        .PRESET_n       (PRESET_n),
        .send_data_i    (send_data_i),
        .mosi_data_i    (mosi_data_i),
        .mstr_i         (mstr_i),
        .cpol_i         (cpol_i),
        .cpha_i         (cpha_i),
        .lsbfe_i        (lsbfe_i),
        .sppr_i         (sppr_i),
        .spr_i          (spr_i),
        .spi_mode_i     (spi_mode_i),
        .miso_i         (miso_i),
        .sclk_o         (sclk_o),
        .mosi_o         (mosi_o),
        .ss_o           (ss_o),
        .tip_o          (tip_o),
        .receive_data_o (receive_data_o),
        .miso_data_o    (miso_data_o)
    );

    always #5 PCLK = ~PCLK;

    // One expected frame: what the slave must see on MOSI, what the master
    // must report as received, and how long SS must stay low.
    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic        cpol;
        logic        cpha;
        logic        lsbfe;
        int unsigned len;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    function automatic void chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endfunction

    function automatic void fail(input string name, input int act, input int want);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected %0h", name, act, want);
    endfunction

    // bit i of the serial stream for a byte, in the frame's bit order
    function automatic logic sbit(input logic [7:0] b, input logic lsb, input int unsigned i);
        int unsigned k;
        k = (i > 7) ? 7 : i;
        return lsb ? b[k] : b[7-k];
    endfunction

    // ---------------- monitor / SPI slave model / scoreboard ----------------
    exp_t        cur;
    exp_t        got;
    logic        in_frame = 1'b0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic        pulse_prev = 1'b0;
    logic [1:0]  mode_prev = 2'b00;
    int unsigned len, edges, rises, frozen, bit_i, cap_i;
    logic [7:0]  cap;

    always @(negedge PCLK) begin
        if (!PRESET_n) begin
            in_frame   = 1'b0;
            ss_prev    = 1'b1;
            pulse_prev = 1'b0;
        end else begin
            if (ss_prev && !ss_o) begin
                if (expq.size() == 0) begin
                    fail("unexpected_frame", ss_o, 1);
                end else begin
                    cur      = expq[0];
                    in_frame = 1'b1;
                    len = 0; edges = 0; rises = 0; frozen = 0; bit_i = 0; cap_i = 0;
                    cap = 8'h00;
                    sclk_prev = sclk_o;
                    chk("sclk_idle_level", sclk_o, cur.cpol);
                    if (!cur.cpha) slave_miso = sbit(cur.rx, cur.lsbfe, 0);
                end
            end
            if (in_frame && !ss_o) begin
                len++;
                chk("tip_during_frame", tip_o, 1);
                if (sclk_o != sclk_prev) begin
                    edges++;
                    if (sclk_o) rises++;
                    if (mode_prev == 2'b10) frozen++;
                    if ((edges % 2) == 1) begin
                        if (cur.cpha) begin
                            slave_miso = sbit(cur.rx, cur.lsbfe, bit_i);
                            bit_i++;
                        end else if (cap_i < 8) begin
                            if (cur.lsbfe) cap[cap_i] = mosi_o; else cap[7-cap_i] = mosi_o;
                            cap_i++;
                        end
                    end else begin
                        if (cur.cpha) begin
                            if (cap_i < 8) begin
                                if (cur.lsbfe) cap[cap_i] = mosi_o; else cap[7-cap_i] = mosi_o;
                                cap_i++;
                            end
                        end else if (edges < 16) begin
                            bit_i++;
                            slave_miso = sbit(cur.rx, cur.lsbfe, bit_i);
                        end
                    end
                end
            end
            if (receive_data_o) begin
                if (pulse_prev) fail("pulse_width", 2, 1);
                if (expq.size() == 0) begin
                    fail("unexpected_pulse", receive_data_o, 0);
                end else begin
                    got = expq.pop_front();
                    chk("rx_data", miso_data_o, got.rx);
                    chk("mosi_stream", cap, got.tx);
                    chk("frame_len", len, got.len);
                    chk("sclk_edges", edges, 16);
                    chk("sclk_rises", rises, 8);
                    chk("edges_in_stop", frozen, 0);
                    chk("ss_at_pulse", ss_o, 1);
                    chk("tip_at_pulse", tip_o, 0);
                    chk("sclk_end_level", sclk_o, got.cpol);
                    chk("mosi_idle", mosi_o, 0);
                    in_frame = 1'b0;
                    done_cnt++;
                end
            end
            ss_prev    = ss_o;
            pulse_prev = receive_data_o;
        end
        sclk_prev = sclk_o;
        mode_prev = spi_mode_i;
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; issues the request immediately so consecutive calls
    // exercise back-to-back starts.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb,
                            input logic cpol, input logic cpha, input logic lsbfe,
                            input logic [2:0] sppr, input logic [2:0] spr,
                            input logic [1:0] mode, input logic loop,
                            input int unsigned stop_cyc, input bit disturb);
        exp_t        e;
        int unsigned h;
        int          start_done;
        int unsigned waited;
        h = (int'(sppr) + 1) * (1 << spr);
        loop_en = loop; cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsbfe;
        sppr_i = sppr; spr_i = spr; spi_mode_i = mode; mstr_i = 1'b1; mosi_data_i = tx;
        e.tx = tx; e.rx = loop ? tx : sb; e.cpol = cpol; e.cpha = cpha; e.lsbfe = lsbfe;
        e.len = 18 * h + stop_cyc;
        expq.push_back(e);
        start_done = done_cnt;
        send_data_i = 1'b1;
        @(posedge PCLK); #1;
        send_data_i = 1'b0;
        chk("start_ss_low", ss_o, 0);
        chk("start_tip", tip_o, 1);
        waited = 1;
        if (disturb) begin
            repeat (3 * h) @(posedge PCLK);
            #1;
            send_data_i = 1'b1; mosi_data_i = ~tx; cpha_i = ~cpha; cpol_i = ~cpol;
            lsbfe_i = ~lsbfe; sppr_i = sppr + 3'd3; spr_i = spr + 3'd1;
            @(posedge PCLK); #1;
            send_data_i = 1'b0;
            waited += 3 * h + 1;
        end
        if (stop_cyc > 0) begin
            repeat (4 * h) @(posedge PCLK);
            #1 spi_mode_i = 2'b10;
            repeat (stop_cyc) @(posedge PCLK);
            #1 spi_mode_i = mode;
            waited += 4 * h + stop_cyc;
        end
        while (done_cnt == start_done && waited < 18 * h + stop_cyc + 64) begin
            @(posedge PCLK); #1;
            waited++;
        end
        if (done_cnt == start_done) begin
            fail("completion_timeout", waited, e.len);
            expq.delete();
        end
    endtask

    task automatic reject(input logic mstr, input logic [1:0] mode);
        mstr_i = mstr; spi_mode_i = mode; send_data_i = 1'b1;
        @(posedge PCLK); #1;
        send_data_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("reject_ss", ss_o, 1);
            chk("reject_tip", tip_o, 0);
            chk("reject_pulse", receive_data_o, 0);
            @(posedge PCLK); #1;
        end
        mstr_i = 1'b1; spi_mode_i = 2'b00;
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_sclk", sclk_o, 0);
        chk("reset_mosi", mosi_o, 0);
        chk("reset_ss", ss_o, 1);
        chk("reset_tip", tip_o, 0);
        chk("reset_pulse", receive_data_o, 0);
        chk("reset_data", miso_data_o, 0);
        PRESET_n = 1'b1;
        @(posedge PCLK); #1;

        // mode 0, MSB first, H=1, MISO looped to MOSI
        run_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 0, 0);
        // mode 3, LSB first, H=6, slave returns C3
        run_xfer(8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 2'b00, 1'b0, 0, 0);
        // re-request and control changes mid-transfer must be ignored
        run_xfer(8'h5A, 8'h96, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 2'b01, 1'b0, 0, 1);
        // STOP held 20 cycles inside XFER
        run_xfer(8'h81, 8'h7E, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 2'b00, 1'b0, 20, 0);

        reject(1'b0, 2'b00);
        reject(1'b1, 2'b10);

        // reset in the middle of XFER
        cpol_i = 1'b1; cpha_i = 1'b0; lsbfe_i = 1'b0; sppr_i = 3'd1; spr_i = 3'd0;
        mosi_data_i = 8'h69; loop_en = 1'b0; spi_mode_i = 2'b00; mstr_i = 1'b1;
        e.tx = 8'h69; e.rx = 8'h00; e.cpol = 1'b1; e.cpha = 1'b0; e.lsbfe = 1'b0; e.len = 36;
        expq.push_back(e);
        send_data_i = 1'b1;
        @(posedge PCLK); #1;
        send_data_i = 1'b0;
        repeat (8) @(posedge PCLK);
        @(negedge PCLK);
        #2 PRESET_n = 1'b0;
        expq.delete();
        #1;
        chk("midreset_ss", ss_o, 1);
        chk("midreset_sclk", sclk_o, 0);
        chk("midreset_tip", tip_o, 0);
        chk("midreset_mosi", mosi_o, 0);
        chk("midreset_pulse", receive_data_o, 0);
        chk("midreset_data", miso_data_o, 0);
        repeat (3) @(posedge PCLK);
        #1 PRESET_n = 1'b1;
        @(posedge PCLK); #1;
        chk("postreset_pulse", receive_data_o, 0);
        run_xfer(8'hC7, 8'h1B, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 2'b00, 1'b0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            run_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                     2'($urandom_range(0, 1)), 1'b0, 0, 0);
        end

        // largest half-period (1024)
        run_xfer(8'hE1, 8'h2D, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'b00, 1'b0, 0, 0);

        repeat (4) @(posedge PCLK);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Master-mode SPI transfer engine directly downstream of the APB slave interface. Accepts a byte and a one-cycle `send_data_i` request, derives SCLK from the SPPR/SPR baud fields, drives SS/SCLK/MOSI, and shifts in MISO. It returns the received byte with a `receive_data_o` pulse and reports `tip_o`; the APB interface uses `tip_o` for PSLVERR.

## Interface
- `DATA_WIDTH`, 8, transfer length in bits; fixed at 8 for this revision.
- `CNT_WIDTH`, 11, half-period counter width; sized for a maximum half-period of 1024.
- `PCLK` in 1: system clock; all logic on the rising edge.
- `PRESET_n` in 1: asynchronous, active-low reset.
- `send_data_i` in 1: start request pulse.
- `mosi_data_i` in 8: byte to transmit; sampled on the accept cycle.
- `mstr_i`, `cpol_i`, `cpha_i`, `lsbfe_i` in 1 each: control fields from CR1.
- `sppr_i`, `spr_i` in 3 each: baud prescaler and rate fields.
- `spi_mode_i` in 2: 00 run, 01 wait, 10 stop.
- `miso_i` in 1: serial input from the slave.
- `sclk_o` out 1: serial clock.
- `mosi_o` out 1: serial output.
- `ss_o` out 1: active-low slave select.
- `tip_o` out 1: transfer in progress.
- `receive_data_o` out 1: one-cycle done pulse.
- `miso_data_o` out 8: last received byte.

## Operation
- Half-period H = (sppr+1) << spr, in PCLK cycles. Range is 1..1024, computed in 11 bits with no overflow.
- **FSM states:** IDLE, LEAD, XFER, TAIL.
- **IDLE -> LEAD:** taken on `send_data_i` && `mstr_i` && `spi_mode_i` is 00 or 01. This is the accept cycle.
  - Latch cpol, cpha, lsbfe, H and `mosi_data_i` into shadow registers.
  - Changes to these inputs during a transfer are ignored.
- **LEAD:** lasts H cycles, then -> XFER.
- **XFER:** 16 SCLK edges, spaced H cycles apart. After the 16th edge, -> TAIL.
- **TAIL:** lasts H cycles, then -> IDLE.
  - On exit: `ss_o` returns to 1, `tip_o` returns to 0, `miso_data_o` is updated, and `receive_data_o` pulses for one cycle.
- `send_data_i` is ignored unless the block is in IDLE. There is no queueing.
- If `mstr_i` = 0, the request is ignored.
- `sclk_o` idles at the latched cpol and toggles on each edge. Edges 1, 3, … 15 are leading; edges 2, 4, … 16 are trailing.
- **cpha=0:**
  - First data bit is on `mosi_o` from LEAD entry.
  - Sample `miso_i` on leading edges.
  - Shift the next bit out on trailing edges 2..14. Edge 16 shifts nothing.
- **cpha=1:**
  - Shift a bit out on each leading edge; the first bit appears at edge 1.
  - Sample on trailing edges.
- **Bit order:**
  - lsbfe=1: bit 0 first, and received bits fill from bit 0.
  - lsbfe=0: bit 7 first, and received bits fill from bit 7.
- **Stop mode mid-transfer** (`spi_mode_i` = 10 in LEAD/XFER/TAIL):
  - Half-period counter, edge counter and `sclk_o` freeze.
  - `ss_o` and `tip_o` keep their values.
  - The transfer resumes on return to 00/01.
- `mosi_o` = 0 in IDLE.

## Timing
- **Reset values:**
  - `sclk_o` = 0, `mosi_o` = 0, `ss_o` = 1, `tip_o` = 0.
  - `receive_data_o` = 0, `miso_data_o` = 8'h00.
  - FSM in IDLE.
- **Reset mid-transfer:** all outputs return to reset values immediately (async). No done pulse is generated.
- **Start latency:** with accept at cycle N, `ss_o`=0 and `tip_o`=1 from N+1.
- **Transfer length:** from `ss_o` fall to `ss_o` rise is 18·H cycles, frozen cycles excluded.
- **Completion:** `receive_data_o` pulses in the first cycle with `ss_o`=1. `miso_data_o` is valid that same cycle and holds until the next completion.
- **Back-to-back:** a request in the cycle after `receive_data_o` is accepted, so the minimum SS-high gap is 1 cycle.
- **Edge timing:** edge k occurs (k+1)·H cycles after `ss_o` fall. Sampling registers `miso_i` on the same PCLK edge that toggles `sclk_o`.

## Structure
- **Shared package `spi_pkg`:**
  - `spi_mode` encodings: RUN=2'b00, WAIT=2'b01, STOP=2'b10. These are shared with the APB interface.
  - FSM state localparams.
  - `DATA_WIDTH`.
- **Sub-module `spi_baud_gen`:**
  - Computes H and runs the half-period counter with enable/freeze and clear.
  - Emits a one-cycle `edge_tick`.
  - The FSM, edge counter (0..16) and shift registers stay in the top level.

## Test plan
- Mode 0 (cpol=0, cpha=0), lsbfe=0, sppr=0, spr=0, tx 8'hA5, MISO looped to MOSI -> `ss_o` low for exactly 18 cycles, 8 rising SCLK edges, `miso_data_o`=8'hA5 with a single `receive_data_o` pulse.
- Mode 3 (cpol=1, cpha=1), lsbfe=1, sppr=2, spr=1 (H=6), tx 8'h3C, slave drives 8'hC3 -> SCLK idles high, 108-cycle frame, MOSI bit sequence 0,0,1,1,1,1,0,0, `miso_data_o`=8'hC3.
- `send_data_i` re-pulsed mid-transfer, plus `cpha_i`/`sppr_i` changed mid-transfer -> ignored; frame length and data unchanged.
- `spi_mode_i`=10 held for 20 cycles inside XFER -> `sclk_o` frozen, frame extends by exactly 20 cycles, received data correct.
- `mstr_i`=0 request, or request with `spi_mode_i`=10 in IDLE -> `ss_o` stays 1, no `tip_o`, no pulse.
- `PRESET_n` asserted mid-XFER -> `ss_o`=1, `sclk_o`=0, `tip_o`=0 asynchronously, no `receive_data_o`. A subsequent transfer completes normally.
